fetch_align: RTL and testbench

Instruction fetch and realignment unit for the rv32imc core. It runs a private fetch pointer and issues word-aligned requests on the instruction-memory port. It buffers the returned words as halfwords and hands decode one instruction per handshake, either 32-bit or 16-bit compressed, together with that instruction's PC. Execute uses redirect to steer it on branches and jumps. In-flight fetch data is squashed on a redirect.

---
 rtl/fetch_align_if.sv | 30 +++
 rtl/fetch_align.sv | 190 +++++++++++++++++++
 tb/tb_fetch_align.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_align_if.sv
// Bus bundle for the fetch/realign unit.
//   redirect  : redirectEn/redirectPc from execute
//   mem req   : memReqValid/memReqAddr out, memReqReady in
//   mem rsp   : memRspValid/memRspData in
//   decode    : instrValid/instrData/instrPc/instrCompressed out, instrReady in
// modport master is the fetch unit side, modport slave is the core/memory side.
interface fetch_align_if;
  logic        redirectEn;
  logic [31:0] redirectPc;
  logic        memReqValid;
  logic [31:0] memReqAddr;
  logic        memReqReady;
  logic        memRspValid;
  logic [31:0] memRspData;
  logic        instrValid;
  logic [31:0] instrData;
  logic [31:0] instrPc;
  logic        instrCompressed;
  logic        instrReady;

  modport master (
    input  redirectEn, redirectPc, memReqReady, memRspValid, memRspData, instrReady,
    output memReqValid, memReqAddr, instrValid, instrData, instrPc, instrCompressed
  );

  modport slave (
    output redirectEn, redirectPc, memReqReady, memRspValid, memRspData, instrReady,
    input  memReqValid, memReqAddr, instrValid, instrData, instrPc, instrCompressed
  );
endinterface

// File: rtl/fetch_align.sv
// Instruction fetch and realignment unit for an rv32imc core.
// Runs a private word-aligned fetch pointer, keeps at most one request
// outstanding, buffers returned words as halfwords and hands decode one
// instruction (16-bit compressed or 32-bit) per handshake with its PC.
// Ports:
//   clk  : core clock, all state on the rising edge
//   arst : asynchronous reset, active-high
//   bus  : fetch_align_if.master (redirect, memory request/response, decode)
module fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          arst,
  fetch_align_if.master bus
);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state;
  logic        req_vld;
  logic [31:0] fetch_addr;
  logic [31:0] buf_pc;
  logic [1:0]  cnt;
  logic        drop_low;
  logic        discard;
  logic [15:0] hw_buf  [3];
  logic [15:0] buf_nxt [3];

  logic        is_comp;
  logic        instr_vld;
  logic        pop;
  logic        push;
  logic [1:0]  pop_n;
  logic [1:0]  push_n;
  logic [1:0]  rem;
  logic [1:0]  cnt_nxt;
  logic [15:0] push_h0;
  logic [15:0] push_h1;

  always_comb begin
    // Low two bits of the oldest halfword decide the instruction length.
    is_comp   = (hw_buf[0][1:0] != 2'b11);
    instr_vld = ((cnt != 2'd0) && is_comp) || (cnt >= 2'd2);
    // A handshake coinciding with a redirect is not a consumed instruction.
    pop       = instr_vld && bus.instrReady && !bus.redirectEn;
    pop_n     = pop ? (is_comp ? 2'd1 : 2'd2) : 2'd0;
    push      = (state == WAIT) && bus.memRspValid && !discard && !bus.redirectEn;
    push_n    = push ? (drop_low ? 2'd1 : 2'd2) : 2'd0;
    rem       = cnt - pop_n;
    cnt_nxt   = rem + push_n;
    // After a redirect to an odd halfword only the upper half is wanted.
    push_h0   = drop_low ? bus.memRspData[31:16] : bus.memRspData[15:0];
    push_h1   = bus.memRspData[31:16];

    buf_nxt[0] = hw_buf[0];
    buf_nxt[1] = hw_buf[1];
    buf_nxt[2] = hw_buf[2];
    case (pop_n)
      2'd1: begin
        buf_nxt[0] = hw_buf[1];
        buf_nxt[1] = hw_buf[2];
      end
      2'd2: begin
        buf_nxt[0] = hw_buf[2];
      end
      default: ;
    endcase

    // Pushed halfwords land right after whatever survives the pop.
    if (push) begin
      case (rem)
        2'd0: begin
          buf_nxt[0] = push_h0;
          if (push_n == 2'd2) buf_nxt[1] = push_h1;
        end
        2'd1: begin
          buf_nxt[1] = push_h0;
          if (push_n == 2'd2) buf_nxt[2] = push_h1;
        end
        2'd2: buf_nxt[2] = push_h0;
        default: ;
      endcase
    end
  end

  // Halfword storage carries no reset; cnt alone says what is meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) hw_buf[i] <= buf_nxt[i];
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= HOLD;
      req_vld    <= 1'b0;
      cnt        <= 2'd0;
      discard    <= 1'b0;
      fetch_addr <= RESET_PC & ~32'h3;
      buf_pc     <= RESET_PC & ~32'h1;
      drop_low   <= RESET_PC[1];
    end else if (bus.redirectEn) begin
      cnt        <= 2'd0;
      buf_pc     <= bus.redirectPc & ~32'h1;
      fetch_addr <= bus.redirectPc & ~32'h3;
      drop_low   <= bus.redirectPc[1];
      case (state)
        HOLD: begin
          state   <= REQ;
          req_vld <= 1'b1;
        end
        REQ: begin
          // An address accepted this cycle belongs to the old stream.
          if (bus.memReqReady) begin
            state   <= WAIT;
            req_vld <= 1'b0;
            discard <= 1'b1;
          end
        end
        WAIT: begin
          if (bus.memRspValid) begin
            discard <= 1'b0;
            state   <= REQ;
            req_vld <= 1'b1;
          end else begin
            discard <= 1'b1;
          end
        end
        default: begin
          state   <= HOLD;
          req_vld <= 1'b0;
        end
      endcase
    end else begin
      cnt <= cnt_nxt;
      if (pop) buf_pc <= buf_pc + (is_comp ? 32'd2 : 32'd4);
      case (state)
        HOLD: begin
          if (cnt_nxt <= 2'd1) begin
            state   <= REQ;
            req_vld <= 1'b1;
          end
        end
        REQ: begin
          if (bus.memReqReady) begin
            fetch_addr <= fetch_addr + 32'd4;
            state      <= WAIT;
            req_vld    <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.memRspValid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= REQ;
              req_vld <= 1'b1;
            end else begin
              drop_low <= 1'b0;
              // Only refetch when room for a full word is guaranteed.
              if (cnt_nxt <= 2'd1) begin
                state   <= REQ;
                req_vld <= 1'b1;
              end else begin
                state   <= HOLD;
              end
            end
          end
        end
        default: begin
          state   <= HOLD;
          req_vld <= 1'b0;
        end
      endcase
    end
  end

  assign bus.memReqValid     = req_vld;
  assign bus.memReqAddr      = fetch_addr;
  assign bus.instrValid      = instr_vld;
  assign bus.instrCompressed = (cnt != 2'd0) && is_comp;
  assign bus.instrData       = is_comp ? {16'h0000, hw_buf[0]} : {hw_buf[1], hw_buf[0]};
  assign bus.instrPc         = buf_pc;

  // Requests are issued with at most one halfword left, so a push never overflows.
  a_no_overflow: assert property (@(posedge clk) disable iff (arst)
    push |-> (({1'b0, rem} + {1'b0, push_n}) <= 3'd3));

endmodule

// File: tb/tb_fetch_align.sv
// Self-checking bench for fetch_align: a memory responder with random latency
// and acceptance, a reference instruction-stream model walking memory by PC,
// and a scoreboard monitor comparing every decode handshake.
module tb_fetch_align;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  fetch_align_if bus();

  fetch_align #(.RESET_PC(RESET_PC)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        comp;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int unsigned seed;
  int          vectors = 0;
  int          miscompares = 0;
  int          popped = 0;
  int          acc_count = 0;
  logic [31:0] last_acc_addr = 32'h0;
  logic [31:0] exp_fetch = RESET_PC & ~32'h3;
  int          lat_min = 1;
  int          lat_max = 1;
  int          rdy_pct = 100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] wa;
    logic [31:0] h;
    wa = a & ~32'h3;
    if (mem.exists(wa)) return mem[wa];
    h = (wa ^ seed) * 32'h9E37_79B1;
    h = h ^ (h >> 15);
    h = h * 32'h85EB_CA6B;
    h = h ^ (h >> 13);
    return h;
  endfunction

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic void push_exp(input logic [31:0] d, input logic [31:0] pc, input logic c);
    exp_t e;
    e.data = d;
    e.pc   = pc;
    e.comp = c;
    exp_q.push_back(e);
  endfunction

  function automatic void push_stream(input logic [31:0] start, input int n);
    logic [31:0] pc;
    logic [15:0] h0;
    pc = start;
    for (int i = 0; i < n; i++) begin
      h0 = hw_at(pc);
      if (h0[1:0] != 2'b11) begin
        push_exp({16'h0000, h0}, pc, 1'b1);
        pc = pc + 32'd2;
      end else begin
        push_exp({hw_at(pc + 32'd2), h0}, pc, 1'b0);
        pc = pc + 32'd4;
      end
    end
  endfunction

  // ---------------- memory responder ----------------
  initial begin : memory
    bit          acc;
    bit          pending;
    logic [31:0] acc_addr;
    logic [31:0] pend_addr;
    int          delay;
    pending = 0;
    delay = 0;
    pend_addr = 32'h0;
    bus.memReqReady = 1'b0;
    bus.memRspValid = 1'b0;
    bus.memRspData  = 32'h0;
    forever begin
      @(negedge clk);
      acc      = bus.memReqValid && bus.memReqReady && !arst;
      acc_addr = bus.memReqAddr;
      if (acc) begin
        chk("req_addr", acc_addr, exp_fetch);
        acc_count++;
        last_acc_addr = acc_addr;
        exp_fetch = exp_fetch + 32'd4;
      end
      if (arst) exp_fetch = RESET_PC & ~32'h3;
      else if (bus.redirectEn) exp_fetch = bus.redirectPc & ~32'h3;
      @(posedge clk);
      #2;
      bus.memRspValid = 1'b0;
      if (acc) begin
        pending   = 1;
        pend_addr = acc_addr;
        delay     = int'($urandom_range(lat_max, lat_min)) - 1;
      end
      // A response still owed across a reset comes out right after release.
      if (pending && arst) delay = 0;
      if (pending && !arst) begin
        if (delay <= 0) begin
          bus.memRspValid = 1'b1;
          bus.memRspData  = word_at(pend_addr);
          pending = 0;
        end else begin
          delay--;
        end
      end
      bus.memReqReady = (int'($urandom_range(99, 0)) < rdy_pct);
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    bit   prev_redir;
    exp_t e;
    prev_redir = 0;
    forever begin
      @(negedge clk);
      if (arst) begin
        prev_redir = 0;
      end else begin
        if (prev_redir) chk("valid_after_redirect", {31'h0, bus.instrValid}, 32'h0);
        prev_redir = bus.redirectEn;
        if (bus.instrValid && bus.instrReady && !bus.redirectEn) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL instr_unexpected: got %h @%h, required none", bus.instrData, bus.instrPc);
          end else begin
            e = exp_q.pop_front();
            chk("instr_data", bus.instrData, e.data);
            chk("instr_pc", bus.instrPc, e.pc);
            chk("instr_comp", {31'h0, bus.instrCompressed}, {31'h0, e.comp});
            popped++;
          end
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    arst = 1'b1;
    bus.redirectEn = 1'b0;
    exp_q.delete();
    repeat (n) begin
      @(negedge clk);
      chk("rst_req_valid", {31'h0, bus.memReqValid}, 32'h0);
      chk("rst_instr_valid", {31'h0, bus.instrValid}, 32'h0);
      chk("rst_instr_comp", {31'h0, bus.instrCompressed}, 32'h0);
      @(posedge clk);
      #1;
    end
    arst = 1'b0;
  endtask

  task automatic issue_redirect(input logic [31:0] pc);
    bus.redirectEn = 1'b1;
    bus.redirectPc = pc;
    cyc(1);
    bus.redirectEn = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    exp_q.delete();
    push_stream(pc & ~32'h1, 80);
    issue_redirect(pc);
  endtask

  task automatic wait_first_req();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.memReqValid && n < 2);
    chk("first_req_valid", {31'h0, bus.memReqValid}, 32'h1);
    chk("first_req_addr", bus.memReqAddr, RESET_PC & ~32'h3);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int budget, input string name);
    int a0;
    int c;
    a0 = acc_count;
    c = 0;
    while (acc_count == a0 && c < budget) begin
      cyc(1);
      c++;
    end
    vectors++;
    if (acc_count == a0) begin
      miscompares++;
      $display("FAIL %s: no request accepted in %0d cycles, required one", name, budget);
    end
  endtask

  task automatic wait_consumed(input int k, input int budget, input string name);
    int start;
    int c;
    start = popped;
    c = 0;
    while (popped < start + k && c < budget) begin
      cyc(1);
      c++;
    end
    vectors++;
    if (popped < start + k) begin
      miscompares++;
      $display("FAIL %s: consumed %0d instructions, required %0d", name, popped - start, k);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    logic [31:0] tgt;
    int          rp;
    int          len;
    arst = 1'b1;
    bus.redirectEn = 1'b0;
    bus.redirectPc = 32'h0;
    bus.instrReady = 1'b1;
    seed = $urandom;
    cyc(1);

    // Reset, then first 32-bit instruction at RESET_PC
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    mem.delete();
    mem[32'h0] = 32'h00A00093;
    do_reset(3);
    push_exp(32'h00A00093, 32'h0, 1'b0);
    push_stream(32'h4, 40);
    wait_first_req();
    wait_consumed(1, 20, "first_instr");

    // Compressed pair in one word
    mem.delete();
    mem[32'h0] = 32'h45014485;
    do_reset(2);
    push_exp(32'h00004485, 32'h0, 1'b1);
    push_exp(32'h00004501, 32'h2, 1'b1);
    push_stream(32'h4, 40);
    wait_consumed(2, 20, "comp_pair");

    // 32-bit instruction straddling two words
    mem.delete();
    mem[32'h0] = 32'h00930001;
    mem[32'h4] = 32'h123400A0;
    do_reset(2);
    push_exp(32'h00000001, 32'h0, 1'b1);
    push_exp(32'h00A00093, 32'h2, 1'b0);
    push_exp(32'h00001234, 32'h6, 1'b1);
    push_stream(32'h8, 40);
    wait_consumed(3, 30, "straddle");

    // Redirect while a response is outstanding
    mem.delete();
    mem[32'h100] = 32'h45050001;
    lat_min = 4; lat_max = 4;
    do_reset(2);
    push_stream(32'h0, 40);
    wait_acc(10, "acc_before_redirect");
    exp_q.delete();
    push_exp(32'h00004505, 32'h102, 1'b1);
    push_stream(32'h104, 40);
    issue_redirect(32'h102);
    wait_acc(30, "acc_after_redirect");
    chk("redir_req_addr", last_acc_addr, 32'h100);
    wait_consumed(1, 30, "redir_instr");

    // Backpressure: decode stalled while the buffer fills
    mem.delete();
    lat_min = 1; lat_max = 1;
    bus.instrReady = 1'b0;
    do_reset(2);
    push_stream(32'h0, 40);
    cyc(4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_req_idle", {31'h0, bus.memReqValid}, 32'h0);
      chk("bp_instr_valid", {31'h0, bus.instrValid}, 32'h1);
      @(posedge clk);
      #1;
    end
    bus.instrReady = 1'b1;
    wait_consumed(4, 40, "bp_drain");

    // Reset while waiting; the late response must be ignored
    lat_min = 3; lat_max = 3;
    do_reset(2);
    push_stream(32'h0, 80);
    wait_acc(10, "acc_pre_rst1");
    wait_acc(20, "acc_pre_rst2");
    do_reset(2);
    push_stream(RESET_PC & ~32'h1, 80);
    wait_first_req();
    wait_consumed(3, 60, "rst_restart");

    // Randomized redirects, resets, latencies and decode stalls
    mem.delete();
    for (int s = 0; s < 250; s++) begin
      lat_min = 1;
      lat_max = int'($urandom_range(4, 1));
      rdy_pct = int'($urandom_range(100, 30));
      rp      = int'($urandom_range(100, 20));
      if ($urandom_range(14, 0) == 0) begin
        do_reset(int'($urandom_range(3, 1)));
        push_stream(RESET_PC & ~32'h1, 80);
      end else begin
        if ($urandom_range(7, 0) == 0) tgt = 32'hFFFF_FFF0 + $urandom_range(15, 0);
        else tgt = $urandom_range(32'h3FF, 0);
        redirect(tgt);
      end
      len = int'($urandom_range(40, 3));
      repeat (len) begin
        bus.instrReady = (int'($urandom_range(99, 0)) < rp);
        cyc(1);
      end
    end

    // Full-rate drain
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    bus.instrReady = 1'b1;
    redirect(32'h200);
    wait_consumed(20, 120, "drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
